vga_cell_tic: RTL and testbench

- Parametrised character-cell timing counter for the text-mode VGA pipeline.
- Sits after the horizontal active-video enable. Divides the pixel clock into CELL_W-pixel character cells and counts cells across the active line.
- Outputs the in-cell pixel index, the cell column index, a per-cell tick and an end-of-line tick.
- Adds a fine horizontal scroll phase and a bounded line length: counting stops after COLS cells until the enable drops.

---
 rtl/vga_cell_tic.sv | 90 +++++++++
 tb/tb_vga_cell_tic.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vga_cell_tic.sv
// Character-cell timing counter: splits the active line into CELL_W-pixel cells,
// emits a per-cell tick and an end-of-line tick, and supports a fine scroll phase.
module vga_cell_tic #(
    parameter  int unsigned CELL_W = 10,
    parameter  int unsigned COLS   = 64,
    localparam int unsigned PX_W   = ($clog2(CELL_W) > 1) ? $clog2(CELL_W) : 1,
    localparam int unsigned COL_W  = ($clog2(COLS) > 1) ? $clog2(COLS) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en_h,
    input  logic [PX_W-1:0]  i_phase,
    output logic [PX_W-1:0]  o_px,
    output logic [COL_W-1:0] o_col,
    output logic             o_t_h,
    output logic             o_t_last,
    output logic             o_done
);

    localparam logic [PX_W-1:0]  PX_LAST  = PX_W'(CELL_W - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    logic [PX_W-1:0]  r_px     = '0;
    logic [COL_W-1:0] r_col    = '0;
    logic             r_t_h    = 1'b0;
    logic             r_t_last = 1'b0;
    logic             r_done   = 1'b0;

    logic [PX_W-1:0]  w_phase_eff;
    logic [PX_W-1:0]  w_px_d;
    logic [COL_W-1:0] w_col_d;
    logic             w_t_h_d;
    logic             w_t_last_d;
    logic             w_done_d;

    // Out-of-range scroll phases fall back to a full-length first cell.
    always_comb begin
        w_phase_eff = (32'(i_phase) < CELL_W) ? i_phase : '0;
    end

    always_comb begin
        w_px_d     = r_px;
        w_col_d    = r_col;
        w_t_h_d    = 1'b0;
        w_t_last_d = 1'b0;
        w_done_d   = r_done;
        if (!i_en_h) begin
            w_px_d   = w_phase_eff;
            w_col_d  = '0;
            w_done_d = 1'b0;
        end else if (r_done) begin
            w_done_d = 1'b1;
        end else if (r_px == PX_LAST) begin
            w_px_d  = '0;
            w_t_h_d = 1'b1;
            if (r_col == COL_LAST) begin
                w_col_d    = '0;
                w_t_last_d = 1'b1;
                w_done_d   = 1'b1;
            end else begin
                w_col_d = r_col + COL_W'(1);
            end
        end else begin
            w_px_d = r_px + PX_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_px     <= '0;
            r_col    <= '0;
            r_t_h    <= 1'b0;
            r_t_last <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_px     <= w_px_d;
            r_col    <= w_col_d;
            r_t_h    <= w_t_h_d;
            r_t_last <= w_t_last_d;
            r_done   <= w_done_d;
        end
    end

    assign o_px     = r_px;
    assign o_col    = r_col;
    assign o_t_h    = r_t_h;
    assign o_t_last = r_t_last;
    assign o_done   = r_done;

endmodule

// File: tb/tb_vga_cell_tic.sv
// Directed bench for vga_cell_tic: default geometry plus CELL_W=2/COLS=1 and
// CELL_W=8/COLS=4 instances, checked against a pixel-position model.
module tb_vga_cell_tic;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en1, en2, en3;
    logic [3:0] ph1;
    logic [0:0] ph2;
    logic [2:0] ph3;

    logic [3:0] px1;
    logic [5:0] col1;
    logic       th1, tl1, dn1;
    logic [0:0] px2;
    logic [0:0] col2;
    logic       th2, tl2, dn2;
    logic [2:0] px3;
    logic [1:0] col3;
    logic       th3, tl3, dn3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vga_cell_tic u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en_h(en1), .i_phase(ph1),
        .o_px(px1), .o_col(col1), .o_t_h(th1), .o_t_last(tl1), .o_done(dn1)
    );

    vga_cell_tic #(.CELL_W(2), .COLS(1)) u_dut_min (
        .i_clk(clk), .i_rst_n(rst_n), .i_en_h(en2), .i_phase(ph2),
        .o_px(px2), .o_col(col2), .o_t_h(th2), .o_t_last(tl2), .o_done(dn2)
    );

    vga_cell_tic #(.CELL_W(8), .COLS(4)) u_dut_small (
        .i_clk(clk), .i_rst_n(rst_n), .i_en_h(en3), .i_phase(ph3),
        .o_px(px3), .o_col(col3), .o_t_h(th3), .o_t_last(tl3), .o_done(dn3)
    );

    task automatic check(input string tag, input int obs, input int exp_v);
        n_tests++;
        if (obs != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps n enabled cycles on one instance; f is the effective start pixel.
    task automatic run_line(input int inst, input int f, input int n, input string tag);
        int cw, cols, p, k, ticks_o, ticks_e;
        int px_o, col_o, th_o, tl_o, dn_o;
        int px_e, col_e, th_e, tl_e, dn_e;
        ticks_o = 0;
        ticks_e = 0;
        case (inst)
            1:       begin cw = 10; cols = 64; end
            2:       begin cw = 2;  cols = 1;  end
            default: begin cw = 8;  cols = 4;  end
        endcase
        for (int c = 1; c <= n; c++) begin
            step();
            case (inst)
                1: begin
                    px_o = int'(px1); col_o = int'(col1);
                    th_o = int'(th1); tl_o = int'(tl1); dn_o = int'(dn1);
                end
                2: begin
                    px_o = int'(px2); col_o = int'(col2);
                    th_o = int'(th2); tl_o = int'(tl2); dn_o = int'(dn2);
                end
                default: begin
                    px_o = int'(px3); col_o = int'(col3);
                    th_o = int'(th3); tl_o = int'(tl3); dn_o = int'(dn3);
                end
            endcase
            p    = f + c;
            k    = p / cw;
            dn_e = (p >= cw * cols) ? 1 : 0;
            th_e = ((p % cw == 0) && k >= 1 && k <= cols) ? 1 : 0;
            tl_e = (p == cw * cols) ? 1 : 0;
            px_e = dn_e ? 0 : p % cw;
            col_e = dn_e ? 0 : k;
            ticks_o += th_o;
            ticks_e += th_e;
            check($sformatf("%s px c=%0d", tag, c), px_o, px_e);
            check($sformatf("%s col c=%0d", tag, c), col_o, col_e);
            check($sformatf("%s t_h c=%0d", tag, c), th_o, th_e);
            check($sformatf("%s t_last c=%0d", tag, c), tl_o, tl_e);
            check($sformatf("%s done c=%0d", tag, c), dn_o, dn_e);
        end
        check($sformatf("%s tick_count", tag), ticks_o, ticks_e);
    endtask

    task automatic check_idle1(input string tag, input int px_e);
        check({tag, " px"}, int'(px1), px_e);
        check({tag, " col"}, int'(col1), 0);
        check({tag, " t_h"}, int'(th1), 0);
        check({tag, " t_last"}, int'(tl1), 0);
        check({tag, " done"}, int'(dn1), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        en1 = 1'b0; en2 = 1'b0; en3 = 1'b0;
        ph1 = 4'd0; ph2 = 1'b0; ph3 = 3'd0;
        step();
        step();
        check_idle1("reset", 0);
        check("reset min done", int'(dn2), 0);
        check("reset small px", int'(px3), 0);

        // Full default line, phase 0
        rst_n = 1'b1;
        step();
        en1 = 1'b1;
        run_line(1, 0, 700, "A");

        // Phase 3 loaded while low; phase changes while high are ignored
        en1 = 1'b0;
        ph1 = 4'd3;
        step();
        check_idle1("B load", 3);
        en1 = 1'b1;
        ph1 = 4'd5;
        run_line(1, 3, 700, "B");

        // Out-of-range phase behaves as 0; line truncated at cycle 55
        en1 = 1'b0;
        ph1 = 4'd12;
        step();
        check_idle1("C load", 0);
        en1 = 1'b1;
        run_line(1, 0, 55, "C");
        ph1 = 4'd3;
        en1 = 1'b0;
        step();
        check_idle1("C drop", 3);

        // Single-cycle enable pulse advances once then reloads
        en1 = 1'b1;
        step();
        check("D pulse px", int'(px1), 4);
        check("D pulse t_h", int'(th1), 0);
        en1 = 1'b0;
        step();
        check_idle1("D reload", 3);

        // Reset mid-line at enabled cycle 25
        ph1 = 4'd0;
        step();
        en1 = 1'b1;
        run_line(1, 0, 24, "E1");
        rst_n = 1'b0;
        step();
        check_idle1("E reset", 0);
        rst_n = 1'b1;
        run_line(1, 0, 15, "E2");
        en1 = 1'b0;

        // Degenerate CELL_W=2, COLS=1
        en2 = 1'b1;
        run_line(2, 0, 6, "F");
        en2 = 1'b0;

        // CELL_W=8, COLS=4
        en3 = 1'b1;
        run_line(3, 0, 40, "G");
        en3 = 1'b0;
        step();
        check("G reload done", int'(dn3), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
